qq_sort_queue: RTL and testbench
================================

QQ_SORT_QUEUE -- requirements
Module: qq_sort_queue

Interface
REQ-001 The module SHALL declare parameter DATA_W, default 32, meaning key/data width in bits.
REQ-002 The module SHALL declare parameter DEPTH, default 16, meaning number of storage slots (legal range 2 to 256).
REQ-003 The module SHALL declare parameter MIN_FIRST, default 1, meaning 1 dequeues the smallest key first and 0 dequeues the largest.
REQ-004 The module SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The module SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 The module SHALL have port enq_valid, input, 1 bit: enqueue request.
REQ-007 The module SHALL have port enq_data, input, DATA_W bits: key to insert.
REQ-008 The module SHALL have port enq_ready, output, 1 bit: enqueue accepted this cycle when high together with enq_valid.
REQ-009 The module SHALL have port deq_ready, input, 1 bit: consumer takes the head this cycle.
REQ-010 The module SHALL have port deq_valid, output, 1 bit: the head is valid.
REQ-011 The module SHALL have port deq_data, output, DATA_W bits: the head key, equal to slot[0].
REQ-012 The module SHALL have port drain, input, 1 bit: a one-cycle pulse requesting a drain.
REQ-013 The module SHALL have port count, output, $clog2(DEPTH+1) bits: number of occupied slots.
REQ-014 The module SHALL have ports full and empty, outputs, 1 bit each.
REQ-015 The module SHALL have ports evict_valid (output, 1 bit) and evict_data (output, DATA_W bits): overflow eviction.

Function
REQ-016 Slots slot[0..count-1] SHALL always be sorted with the priority element in slot[0]; unused slots SHALL be don't-care but are held at 0.
REQ-017 An enqueue (enq_valid and enq_ready) SHALL insert the key at its sorted position in one cycle, shifting lower-priority entries by one, and SHALL be visible on deq_data the next cycle.
REQ-018 Keys SHALL be treated as unsigned; among equal keys, the earlier-enqueued key SHALL dequeue first.
REQ-019 A dequeue (deq_valid and deq_ready) SHALL remove slot[0] and shift all entries toward slot[0] in the same edge.
REQ-020 A simultaneous enqueue and dequeue SHALL keep count unchanged and SHALL produce the same ordering as a dequeue followed by an enqueue, including when full.
REQ-021 A simultaneous enqueue and dequeue on an empty queue SHALL accept the enqueue only, because deq_valid=0.
REQ-022 The state machine SHALL have two states, RUN and DRAIN; RUN→DRAIN when drain=1, and DRAIN→RUN on the cycle count reaches 0.
REQ-023 In DRAIN, enq_ready SHALL be 0 and dequeues SHALL proceed normally; a drain pulse while empty SHALL return to RUN the next cycle.
REQ-024 In RUN without overflow eviction, enq_ready SHALL be (!full || deq_ready).
REQ-025 Outputs SHALL be: empty=(count==0), full=(count==DEPTH), deq_valid=!empty.
REQ-026 count SHALL never exceed DEPTH or go below 0.

Reset
REQ-027 While rst=1, all slots SHALL be cleared and count=0, state=RUN, empty=1, full=0, deq_valid=0, deq_data=0, enq_ready=0, evict_valid=0, evict_data=0.
REQ-028 Reset asserted mid-operation, including mid-DRAIN, SHALL discard all contents with no evict or dequeue pulse.
REQ-029 enq_ready SHALL rise no earlier than the first clock edge after rst deasserts.

Configuration
REQ-030 When macro QQ_OVERFLOW_EVICT_EN is defined, enq_ready SHALL be 1 in RUN even when full; a full enqueue without dequeue SHALL insert the key and evict the lowest-priority element among the DEPTH+1 candidates onto evict_data, with evict_valid high for one cycle.
REQ-031 When the evicted candidate under QQ_OVERFLOW_EVICT_EN is the incoming key itself, the slots SHALL be unchanged.
REQ-032 When QQ_OVERFLOW_EVICT_EN is undefined, evict_valid and evict_data SHALL be tied to 0 and REQ-024 SHALL apply.

Verification
REQ-033 Scenario: DEPTH=4, MIN_FIRST=1, enqueue 7,3,9,3, then dequeue 4 times -> outputs 3,3,7,9 in order, with the first 3 enqueued leaving first, and empty=1 after the last dequeue.
REQ-034 Scenario: full queue {1,2,5,8} with enq 4 and deq in the same cycle -> 1 dequeued, contents {2,4,5,8}, count stays 4.
REQ-035 Scenario: QQ_OVERFLOW_EVICT_EN defined, full {1,2,5,8}, enq 3 -> evict_data=8 with evict_valid pulsed for one cycle, contents {1,2,3,5}; then enq 9 -> evict_data=9, contents unchanged.
REQ-036 Scenario: macro undefined, full queue, enq_valid=1 and deq_ready=0 -> enq_ready=0, contents and count unchanged.
REQ-037 Scenario: 3 entries, drain pulse with deq_ready=1 -> enq_ready=0 for 3 cycles, 3 dequeues, then state returns to RUN and enq_ready=1.
REQ-038 Scenario: MIN_FIRST=0, enqueue 0x0, 0xFFFFFFFF, 0x10 -> dequeue order 0xFFFFFFFF, 0x10, 0x0; rst asserted mid-sequence -> count=0 at once.

Source files
------------

// File: rtl/qq_sort_queue.sv
// qq_sort_queue: single-cycle sorted priority queue built from a shift-register
// array. slot[0] always holds the highest-priority key; inserts land at their
// sorted position and dequeues shift everything toward slot[0].
// Optional feature: define QQ_OVERFLOW_EVICT_EN to accept enqueues while full,
// evicting the lowest-priority of the DEPTH+1 candidates onto evict_data.
module qq_sort_queue #(
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 16,
  parameter int MIN_FIRST = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       enq_valid,
  input  logic [DATA_W-1:0]          enq_data,
  output logic                       enq_ready,
  input  logic                       deq_ready,
  output logic                       deq_valid,
  output logic [DATA_W-1:0]          deq_data,
  input  logic                       drain,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty,
  output logic                       evict_valid,
  output logic [DATA_W-1:0]          evict_data
);

  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic {RUN, DRAIN} state_t;

  state_t            state, state_n;
  logic              init_done;
  logic [DATA_W-1:0] slot   [DEPTH];
  logic [DATA_W-1:0] slot_n [DEPTH];
  logic [DATA_W-1:0] base   [DEPTH];
  logic [DATA_W-1:0] ext    [DEPTH];
  logic [CW-1:0]     cnt_b, pos, count_n;
  logic              do_enq, do_deq, evict_now;

  // True when key a must leave before key b; ties are never "before", which
  // keeps equal keys in arrival order.
  function automatic logic beats(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    return (MIN_FIRST != 0) ? (a < b) : (a > b);
  endfunction

  assign empty     = (count == '0);
  assign full      = (count == DEPTH_C);
  assign deq_valid = !empty;
  assign deq_data  = slot[0];

  // Datapath: apply the dequeue shift first, then insert into the shifted array,
  // so a combined enq+deq orders exactly like dequeue-then-enqueue.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    do_deq    = deq_valid && deq_ready;
    do_enq    = enq_valid && enq_ready;
    cnt_b     = count - {{(CW-1){1'b0}}, do_deq};
    pos       = cnt_b;
    evict_now = do_enq && (cnt_b == DEPTH_C);

    for (int j = 0; j < DEPTH - 1; j++)
      base[j] = do_deq ? slot[j+1] : slot[j];
    base[DEPTH-1] = do_deq ? '0 : slot[DEPTH-1];

    // First occupied position whose key the new key strictly beats.
    for (int j = DEPTH - 1; j >= 0; j--)
      if ((CW'(j) < cnt_b) && beats(enq_data, base[j]))
        pos = CW'(j);

    ext[0] = (pos == '0) ? enq_data : base[0];
    for (int j = 1; j < DEPTH; j++) begin
      if (CW'(j) < pos)       ext[j] = base[j];
      else if (CW'(j) == pos) ext[j] = enq_data;
      else                    ext[j] = base[j-1];
    end

    // When pos == DEPTH the incoming key falls off the end: ext equals base.
    for (int j = 0; j < DEPTH; j++)
      slot_n[j] = do_enq ? ext[j] : base[j];

    count_n = evict_now ? count : (cnt_b + {{(CW-1){1'b0}}, do_enq});
  end

  // Slot array and occupancy register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the storage is reset on purpose; unused slots must read as 0 and
      // reset must discard all contents, so this array is not left as plain RAM.
      for (int j = 0; j < DEPTH; j++) slot[j] <= '0;
      count <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only.
      for (int j = 0; j < DEPTH; j++) slot[j] <= slot_n[j];
      count <= count_n;
    end
  end

  // Holds enq_ready low until the first clock edge after reset release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) init_done <= 1'b0;
    else     init_done <= 1'b1;
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= RUN;
    else     state <= state_n;
  end

  // FSM next state: leave DRAIN on the edge where occupancy becomes zero.
  always_comb begin
    state_n = state;
    case (state)
      RUN:     if (drain) state_n = DRAIN;
      DRAIN:   if (count_n == '0) state_n = RUN;
      default: state_n = RUN;
    endcase
  end

  // FSM outputs: enqueue acceptance. A drain pulse also blocks enqueue in the
  // cycle it is raised so that no key slips in behind the drain request.
  always_comb begin
`ifdef QQ_OVERFLOW_EVICT_EN
    enq_ready = init_done && (state == RUN) && !drain;
`else
    enq_ready = init_done && (state == RUN) && !drain && (!full || deq_ready);
`endif
  end

`ifdef QQ_OVERFLOW_EVICT_EN
  logic [DATA_W-1:0] evict_key;

  // Lowest-priority candidate among the DEPTH stored keys plus the new one.
  always_comb begin
    evict_key = (pos == DEPTH_C) ? enq_data : base[DEPTH-1];
  end

  // One-cycle eviction pulse, aligned with the updated slot contents.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      evict_valid <= 1'b0;
      evict_data  <= '0;
    end else begin
      evict_valid <= evict_now;
      evict_data  <= evict_now ? evict_key : '0;
    end
  end
`else
  assign evict_valid = 1'b0;
  assign evict_data  = '0;
`endif

endmodule

// File: tb/tb_qq_sort_queue.sv
// Directed bench for qq_sort_queue. Instance a: DEPTH=4, smallest first.
// Instance b: DEPTH=4, largest first. Expected dequeue order comes from
// sorted scoreboards filled as keys are driven.
module tb_qq_sort_queue;

  localparam int DW = 32;
  localparam int CW = 3;

  logic          clk = 1'b0;
  always #5 clk = ~clk;

  // Instance a
  logic          rst_a, enq_valid_a, deq_ready_a, drain_a;
  logic [DW-1:0] enq_data_a, deq_data_a, evict_data_a;
  logic          enq_ready_a, deq_valid_a, full_a, empty_a, evict_valid_a;
  logic [CW-1:0] count_a;

  // Instance b
  logic          rst_b, enq_valid_b, deq_ready_b, drain_b;
  logic [DW-1:0] enq_data_b, deq_data_b, evict_data_b;
  logic          enq_ready_b, deq_valid_b, full_b, empty_b, evict_valid_b;
  logic [CW-1:0] count_b;

  qq_sort_queue #(.DATA_W(DW), .DEPTH(4), .MIN_FIRST(1)) u_dut_a (
    .clk(clk), .rst(rst_a), .enq_valid(enq_valid_a), .enq_data(enq_data_a),
    .enq_ready(enq_ready_a), .deq_ready(deq_ready_a), .deq_valid(deq_valid_a),
    .deq_data(deq_data_a), .drain(drain_a), .count(count_a), .full(full_a),
    .empty(empty_a), .evict_valid(evict_valid_a), .evict_data(evict_data_a)
  );

  qq_sort_queue #(.DATA_W(DW), .DEPTH(4), .MIN_FIRST(0)) u_dut_b (
    .clk(clk), .rst(rst_b), .enq_valid(enq_valid_b), .enq_data(enq_data_b),
    .enq_ready(enq_ready_b), .deq_ready(deq_ready_b), .deq_valid(deq_valid_b),
    .deq_data(deq_data_b), .drain(drain_b), .count(count_b), .full(full_b),
    .empty(empty_b), .evict_valid(evict_valid_b), .evict_data(evict_data_b)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [DW-1:0] sb_a[$];
  logic [DW-1:0] sb_b[$];
  logic [DW-1:0] exp_k;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Stable sorted insert: new key goes after every key it does not strictly beat.
  task automatic push_a(input logic [DW-1:0] k);
    int p = sb_a.size();
    for (int i = sb_a.size() - 1; i >= 0; i--) if (k < sb_a[i]) p = i;
    sb_a.insert(p, k);
  endtask

  task automatic push_b(input logic [DW-1:0] k);
    int p = sb_b.size();
    for (int i = sb_b.size() - 1; i >= 0; i--) if (k > sb_b[i]) p = i;
    sb_b.insert(p, k);
  endtask

  task automatic enq_a(input logic [DW-1:0] k);
    enq_valid_a = 1'b1; enq_data_a = k;
    #1;
    check("enq_ready_a", enq_ready_a, 1);
    tick();
    enq_valid_a = 1'b0;
    push_a(k);
  endtask

  task automatic deq_a();
    deq_ready_a = 1'b1;
    #1;
    check("deq_valid_a", deq_valid_a, 1);
    exp_k = sb_a.pop_front();
    check("deq_data_a", deq_data_a, exp_k);
    tick();
    deq_ready_a = 1'b0;
  endtask

  task automatic enq_b(input logic [DW-1:0] k);
    enq_valid_b = 1'b1; enq_data_b = k;
    #1;
    check("enq_ready_b", enq_ready_b, 1);
    tick();
    enq_valid_b = 1'b0;
    push_b(k);
  endtask

  task automatic deq_b();
    deq_ready_b = 1'b1;
    #1;
    exp_k = sb_b.pop_front();
    check("deq_data_b", deq_data_b, exp_k);
    tick();
    deq_ready_b = 1'b0;
  endtask

  // Hard stop in case the sequence ever stalls.
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_a = 1'b1; enq_valid_a = 1'b0; deq_ready_a = 1'b0; drain_a = 1'b0; enq_data_a = '0;
    rst_b = 1'b1; enq_valid_b = 1'b0; deq_ready_b = 1'b0; drain_b = 1'b0; enq_data_b = '0;
    repeat (3) tick();

    // Reset state
    check("rst_count",       count_a, 0);
    check("rst_empty",       empty_a, 1);
    check("rst_full",        full_a, 0);
    check("rst_deq_valid",   deq_valid_a, 0);
    check("rst_deq_data",    deq_data_a, 0);
    check("rst_enq_ready",   enq_ready_a, 0);
    check("rst_evict_valid", evict_valid_a, 0);
    check("rst_evict_data",  evict_data_a, 0);

    // enq_ready stays low until the first edge after release
    rst_a = 1'b0; rst_b = 1'b0;
    #1;
    check("enq_ready_before_edge", enq_ready_a, 0);
    tick();
    check("enq_ready_after_edge", enq_ready_a, 1);

    // Sort with duplicates: 7,3,9,3 -> 3,3,7,9
    enq_a(32'd7); enq_a(32'd3); enq_a(32'd9); enq_a(32'd3);
    check("fill_count", count_a, 4);
    check("fill_full",  full_a, 1);

`ifndef QQ_OVERFLOW_EVICT_EN
    // Full, enqueue without dequeue is refused
    enq_valid_a = 1'b1; enq_data_a = 32'd4;
    #1;
    check("full_enq_ready", enq_ready_a, 0);
    tick();
    enq_valid_a = 1'b0;
    check("full_hold_count", count_a, 4);
    check("full_hold_head",  deq_data_a, 3);
    check("evict_tied_low",  evict_valid_a, 0);
`endif

    repeat (4) deq_a();
    check("drained_empty", empty_a, 1);
    check("drained_count", count_a, 0);

    // Enq+deq on empty: only the enqueue happens
    enq_valid_a = 1'b1; enq_data_a = 32'd6; deq_ready_a = 1'b1;
    #1;
    check("empty_both_deq_valid", deq_valid_a, 0);
    check("empty_both_enq_ready", enq_ready_a, 1);
    tick();
    enq_valid_a = 1'b0; deq_ready_a = 1'b0;
    push_a(32'd6);
    check("empty_both_count", count_a, 1);
    deq_a();

    // Build full {1,2,5,8}
    enq_a(32'd8); enq_a(32'd1); enq_a(32'd5); enq_a(32'd2);
    check("full2", full_a, 1);

`ifdef QQ_OVERFLOW_EVICT_EN
    enq_a(32'd3);
    void'(sb_a.pop_back());
    check("evict8_valid", evict_valid_a, 1);
    check("evict8_data",  evict_data_a, 8);
    check("evict8_count", count_a, 4);
    tick();
    check("evict_pulse_one_cycle", evict_valid_a, 0);
    enq_a(32'd9);
    void'(sb_a.pop_back());
    check("evict9_valid", evict_valid_a, 1);
    check("evict9_data",  evict_data_a, 9);
    check("evict9_head",  deq_data_a, 1);
`endif

    // Full with simultaneous enq 4 and deq
    enq_valid_a = 1'b1; enq_data_a = 32'd4; deq_ready_a = 1'b1;
    #1;
    check("full_both_enq_ready", enq_ready_a, 1);
    exp_k = sb_a.pop_front();
    check("full_both_deq_data", deq_data_a, exp_k);
    tick();
    enq_valid_a = 1'b0; deq_ready_a = 1'b0;
    push_a(32'd4);
    check("full_both_count", count_a, 4);
    repeat (4) deq_a();
    check("after_full_both_empty", empty_a, 1);

    // Drain with 3 entries and deq_ready held
    enq_a(32'd30); enq_a(32'd10); enq_a(32'd20);
    drain_a = 1'b1; deq_ready_a = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("drain_enq_ready", enq_ready_a, 0);
      exp_k = sb_a.pop_front();
      check("drain_deq_data", deq_data_a, exp_k);
      tick();
      drain_a = 1'b0;
    end
    deq_ready_a = 1'b0;
    #1;
    check("drain_done_enq_ready", enq_ready_a, 1);
    check("drain_done_empty", empty_a, 1);

    // Drain pulse while empty returns to RUN next cycle
    drain_a = 1'b1;
    tick();
    drain_a = 1'b0;
    #1;
    check("empty_drain_blocked", enq_ready_a, 0);
    tick();
    check("empty_drain_run", enq_ready_a, 1);

    // Reset mid-DRAIN discards contents
    enq_a(32'd1); enq_a(32'd2);
    drain_a = 1'b1;
    tick();
    drain_a = 1'b0;
    check("middrain_enq_ready", enq_ready_a, 0);
    rst_a = 1'b1;
    #1;
    sb_a.delete();
    check("middrain_rst_count", count_a, 0);
    check("middrain_rst_deq_valid", deq_valid_a, 0);
    check("middrain_rst_evict", evict_valid_a, 0);
    check("middrain_rst_deq_data", deq_data_a, 0);
    rst_a = 1'b0;
    tick();
    check("post_rst_enq_ready", enq_ready_a, 1);
    check("post_rst_count", count_a, 0);

    // Largest-first ordering with extreme keys
    enq_b(32'h0); enq_b(32'hFFFF_FFFF); enq_b(32'h10);
    check("b_head", deq_data_b, 32'hFFFF_FFFF);
    deq_b(); deq_b();
    enq_b(32'h5);
    check("b_count", count_b, 2);
    deq_b();
    // Reset mid-sequence clears at once
    enq_b(32'h7);
    rst_b = 1'b1;
    #1;
    sb_b.delete();
    check("b_rst_count", count_b, 0);
    check("b_rst_empty", empty_b, 1);
    rst_b = 1'b0;
    tick();
    enq_b(32'h3);
    deq_b();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
